param_stack_unit: RTL and testbench

- Parametrised LIFO stack with an internal stack pointer. Replaces the fixed 8-bit, 32-entry, externally addressed stack_register in the Fibonacci ASIC datapath.
- The FSM drives push/pop only; the stack tracks the pointer itself.
- Adds full/empty status, occupancy count, registered top-of-stack, a popped-data valid strobe, and sticky overflow/underflow error flags.

---
 rtl/param_stack_unit.sv | 157 +++++++++++++++
 tb/tb_param_stack_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/param_stack_unit.sv
// -----------------------------------------------------------------------------
// param_stack_unit
//   Parametrised LIFO stack with an internal stack pointer. The controller only
//   issues push/pop commands; the stack keeps its own occupancy count, exposes
//   a registered top-of-stack, a popped-data strobe and sticky error flags.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  number of entries (>= 2)
//   CNT_W  width of count; 2**CNT_W > DEPTH
//
// Ports
//   clk           rising-edge clock
//   reset_button  synchronous active-high reset (dominates all other inputs)
//   push, pop     per-cycle commands (may be asserted together = replace top)
//   val_in        data to push
//   clear_err     clears sticky overflow/underflow (a same-cycle error wins)
//   val_out       registered top of stack, 0 when empty
//   pop_data      value removed by the last accepted pop
//   pop_valid     one-cycle strobe: pop_data updated by an accepted pop
//   count         occupancy 0..DEPTH
//   empty, full   decodes of count
//   overflow      sticky: push attempted while full
//   underflow     sticky: pop attempted while empty
//
// Optional feature (macro STACK_PEEK_EN)
//   peek_en, peek_addr  registered random read of an occupied entry
//   peek_data           mem[peek_addr] if peek_addr < count, else 0
//
// Command semantics: push and pop carry no ready/backpressure. Each is a
// single-cycle command that is always consumed at the clock edge where it is
// high; illegal commands (push while full, pop while empty) are dropped and
// only raise the matching sticky flag. Results appear the cycle after.
// -----------------------------------------------------------------------------
module param_stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_button,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] val_in,
  input  logic             clear_err,
`ifdef STACK_PEEK_EN
  input  logic             peek_en,
  input  logic [CNT_W-1:0] peek_addr,
  output logic [WIDTH-1:0] peek_data,
`endif
  output logic [WIDTH-1:0] val_out,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] cnt;

  logic [AW-1:0] wr_idx;     // next free slot
  logic [AW-1:0] top_idx;    // current top entry
  logic [AW-1:0] below_idx;  // entry under the top (new top after a pop)
  logic [AW-1:0] mem_waddr;
  logic          mem_we;
  logic          ovf_evt;
  logic          unf_evt;

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

  always_comb begin
    wr_idx    = AW'(cnt);
    top_idx   = AW'(cnt - CNT_W'(1));
    below_idx = AW'(cnt - CNT_W'(2));

    // Replace overwrites the top in place; a push+pop on an empty stack
    // degenerates to a plain push into slot 0.
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    if (push && pop && !empty) begin
      mem_we    = 1'b1;
      mem_waddr = top_idx;
    end else if (push && (pop || !full)) begin
      mem_we    = 1'b1;
      mem_waddr = wr_idx;
    end

    ovf_evt = push && !pop && full;
    unf_evt = pop && empty;
  end

  // Storage is deliberately not reset; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (!reset_button && mem_we) begin
      mem[mem_waddr] <= val_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_button) begin
      cnt       <= '0;
      val_out   <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      // Set has priority over clear so a coinciding error is never lost.
      overflow  <= ovf_evt | (overflow  & ~clear_err);
      underflow <= unf_evt | (underflow & ~clear_err);

      if (push && pop) begin
        if (!empty) begin
          pop_data  <= mem[top_idx];
          pop_valid <= 1'b1;
          val_out   <= val_in;
        end else begin
          cnt     <= CNT_W'(1);
          val_out <= val_in;
        end
      end else if (push) begin
        if (!full) begin
          cnt     <= cnt + CNT_W'(1);
          val_out <= val_in;
        end
      end else if (pop) begin
        if (!empty) begin
          pop_data  <= mem[top_idx];
          pop_valid <= 1'b1;
          cnt       <= cnt - CNT_W'(1);
          val_out   <= (cnt == CNT_W'(1)) ? '0 : mem[below_idx];
        end
      end
    end
  end

`ifdef STACK_PEEK_EN
  // Reads the pre-edge contents, so a same-cycle push/pop is not visible.
  // peek_addr < cnt also guarantees the index is inside the array.
  always_ff @(posedge clk) begin
    if (reset_button) begin
      peek_data <= '0;
    end else if (peek_en) begin
      peek_data <= (peek_addr < cnt) ? mem[AW'(peek_addr)] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_param_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_param_stack_unit
//   Directed bench for param_stack_unit (WIDTH=8, DEPTH=32, CNT_W=6).
//   The driver issues one command per cycle and queues the hand-computed
//   expected state; a monitor on the falling edge pops and compares.
//   Define STACK_PEEK_EN to also exercise the peek port.
// -----------------------------------------------------------------------------
module tb_param_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int CNT_W = 6;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_button;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             push, pop, clear_err;
  logic [WIDTH-1:0] val_in;
  logic [WIDTH-1:0] val_out, pop_data;
  logic             pop_valid, empty, full, overflow, underflow;
  logic [CNT_W-1:0] count;
`ifdef STACK_PEEK_EN
  logic             peek_en;
  logic [CNT_W-1:0] peek_addr;
  logic [WIDTH-1:0] peek_data;
`endif

  param_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_button (reset_button),
    .push         (push),
    .pop          (pop),
    .val_in       (val_in),
    .clear_err    (clear_err),
`ifdef STACK_PEEK_EN
    .peek_en      (peek_en),
    .peek_addr    (peek_addr),
    .peek_data    (peek_data),
`endif
    .val_out      (val_out),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] vo;
    logic             ov;
    logic             un;
    logic             pv;
    logic [WIDTH-1:0] pk;
  } exp_t;

  exp_t             st_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] pk_exp;
  logic             done;
  int               checks;
  int               errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic ps, input logic pp, input logic [WIDTH-1:0] v,
                      input logic clr, input logic rst,
                      input logic [CNT_W-1:0] ec, input logic [WIDTH-1:0] evo,
                      input logic eov, input logic eun,
                      input logic epv, input logic [WIDTH-1:0] epd);
    exp_t e;
    push         = ps;
    pop          = pp;
    val_in       = v;
    clear_err    = clr;
    reset_button = rst;
    @(posedge clk);
    #1;
    e.cnt = ec;
    e.vo  = evo;
    e.ov  = eov;
    e.un  = eun;
    e.pv  = epv;
    e.pk  = pk_exp;
    st_q.push_back(e);
    if (epv) exp_q.push_back(epd);
  endtask

  initial begin
    done         = 1'b0;
    pk_exp       = '0;
    push         = 1'b0;
    pop          = 1'b0;
    val_in       = '0;
    clear_err    = 1'b0;
    reset_button = 1'b1;
`ifdef STACK_PEEK_EN
    peek_en   = 1'b0;
    peek_addr = '0;
`endif
    //    ps pp val clr rst  cnt vo  ov un pv pd
    step(0, 0, 0,  0, 1,   0, 0,  0, 0, 0, 0);   // reset
    // push 7,3,9 then pop 9,3,7
    step(1, 0, 7,  0, 0,   1, 7,  0, 0, 0, 0);
    step(1, 0, 3,  0, 0,   2, 3,  0, 0, 0, 0);
    step(1, 0, 9,  0, 0,   3, 9,  0, 0, 0, 0);
    step(0, 1, 0,  0, 0,   2, 3,  0, 0, 1, 9);
    step(0, 1, 0,  0, 0,   1, 7,  0, 0, 1, 3);
    step(0, 1, 0,  0, 0,   0, 0,  0, 0, 1, 7);
    // underflow, clear, clear coinciding with new error
    step(0, 1, 0,  0, 0,   0, 0,  0, 1, 0, 0);
    step(0, 0, 0,  1, 0,   0, 0,  0, 0, 0, 0);
    step(0, 1, 0,  1, 0,   0, 0,  0, 1, 0, 0);
    step(0, 0, 0,  1, 0,   0, 0,  0, 0, 0, 0);
    // fill to DEPTH, then one push too many
    for (int i = 1; i <= DEPTH; i++)
      step(1, 0, WIDTH'(i), 0, 0, CNT_W'(i), WIDTH'(i), 0, 0, 0, 0);
    step(1, 0, 33, 0, 0,  32, 32, 1, 0, 0, 0);
    step(0, 1, 0,  0, 0,  31, 31, 1, 0, 1, 32);
    step(1, 0, 40, 0, 0,  32, 40, 1, 0, 0, 0);
    step(1, 1, 41, 0, 0,  32, 41, 1, 0, 1, 40);  // replace while full
    step(1, 0, 42, 1, 0,  32, 41, 1, 0, 0, 0);   // overflow set beats clear
    step(0, 0, 0,  0, 1,   0, 0,  0, 0, 0, 0);
    // replace and push+pop on empty
    step(1, 0, 5,  0, 0,   1, 5,  0, 0, 0, 0);
    step(1, 1, 6,  0, 0,   1, 6,  0, 0, 1, 5);
    step(0, 1, 0,  0, 0,   0, 0,  0, 0, 1, 6);
    step(1, 1, 4,  0, 0,   1, 4,  0, 1, 0, 0);
    // reset dominating a push mid-operation
    step(0, 0, 0,  0, 1,   0, 0,  0, 0, 0, 0);
    step(1, 0, 1,  0, 0,   1, 1,  0, 0, 0, 0);
    step(1, 0, 2,  0, 0,   2, 2,  0, 0, 0, 0);
    step(1, 0, 3,  0, 0,   3, 3,  0, 0, 0, 0);
    step(1, 1, 4,  0, 1,   0, 0,  0, 0, 0, 0);
    step(0, 1, 0,  0, 0,   0, 0,  0, 1, 0, 0);   // fresh empty stack
    step(0, 0, 0,  1, 0,   0, 0,  0, 0, 0, 0);
    step(1, 0, 7,  0, 0,   1, 7,  0, 0, 0, 0);
    step(1, 0, 8,  0, 0,   2, 8,  0, 0, 0, 0);
`ifdef STACK_PEEK_EN
    peek_en = 1'b1;
    peek_addr = 0;  pk_exp = 7; step(0, 0, 0, 0, 0, 2, 8, 0, 0, 0, 0);
    peek_addr = 1;  pk_exp = 8; step(0, 0, 0, 0, 0, 2, 8, 0, 0, 0, 0);
    peek_addr = 5;  pk_exp = 0; step(0, 0, 0, 0, 0, 2, 8, 0, 0, 0, 0);
    peek_addr = 1;  pk_exp = 8; step(0, 0, 0, 0, 0, 2, 8, 0, 0, 0, 0);
    peek_addr = 35; pk_exp = 0; step(0, 0, 0, 0, 0, 2, 8, 0, 0, 0, 0);
    peek_en = 1'b0;
    peek_addr = 0;              step(0, 0, 0, 0, 0, 2, 8, 0, 0, 0, 0);  // holds 0
    peek_en = 1'b1;
    peek_addr = 1;  pk_exp = 8;                     // pre-pop contents
`endif
    step(0, 1, 0,  0, 0,   1, 7,  0, 0, 1, 8);
`ifdef STACK_PEEK_EN
    peek_en = 1'b0;
`endif
    step(0, 0, 0,  0, 0,   1, 7,  0, 0, 0, 0);
    @(negedge clk);
    #1;
    done = 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t             e;
    logic [WIDTH-1:0] pd;
    int               cyc;
    checks = 0;
    errors = 0;
    cyc    = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("count",     32'(count),     32'(e.cnt));
        chk("val_out",   32'(val_out),   32'(e.vo));
        chk("empty",     32'(empty),     32'(e.cnt == 0));
        chk("full",      32'(full),      32'(e.cnt == CNT_W'(DEPTH)));
        chk("overflow",  32'(overflow),  32'(e.ov));
        chk("underflow", 32'(underflow), 32'(e.un));
        chk("pop_valid", 32'(pop_valid), 32'(e.pv));
`ifdef STACK_PEEK_EN
        chk("peek_data", 32'(peek_data), 32'(e.pk));
`endif
      end
      if (pop_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("pop_strobe_unexpected", 32'(pop_valid), 32'(0));
        end else begin
          pd = exp_q.pop_front();
          chk("pop_data", 32'(pop_data), 32'(pd));
        end
      end
    end
    if (!done) chk("timeout", 32'(done), 32'(1));
    chk("pop_leftover",  32'(exp_q.size()), 32'(0));
    chk("state_leftover", 32'(st_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
